covariance_calc: RTL and testbench

//  Streaming covariance front-end for the OBB path. Accepts one point cloud (x,y,z) per frame,

---
 rtl/covariance_calc.sv | 206 ++++++++++++++++++++
 tb/tb_covariance_calc.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/covariance_calc.sv
// covariance_calc: streams (x,y,z) points, accumulates sums, then divides out the six
// unique entries of the 3x3 covariance matrix through one shared restoring divider.
module covariance_calc #(
  parameter int COORD_W = 16,
  parameter int CNT_W   = 10,
  parameter int OUT_W   = 21
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      pt_valid,
  output logic                      pt_ready,
  input  logic signed [COORD_W-1:0] pt_x,
  input  logic signed [COORD_W-1:0] pt_y,
  input  logic signed [COORD_W-1:0] pt_z,
  input  logic                      pt_last,
  output logic                      busy,
  output logic                      done,
  output logic                      ovf,
  output logic signed [OUT_W-1:0]   m1,
  output logic signed [OUT_W-1:0]   m2,
  output logic signed [OUT_W-1:0]   m3,
  output logic signed [OUT_W-1:0]   m5,
  output logic signed [OUT_W-1:0]   m6,
  output logic signed [OUT_W-1:0]   m9
);
  localparam int NUM_W = 2*COORD_W+2*CNT_W+2;
  localparam int S1_W  = COORD_W+CNT_W;
  localparam int S2_W  = 2*COORD_W+CNT_W;
  localparam int P_W   = 2*COORD_W;
  localparam int D_W   = 2*CNT_W;
  localparam int IT_W  = $clog2(NUM_W+1);
  localparam logic [NUM_W-1:0] LIM = NUM_W'(1) << (OUT_W-1);
  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ACC, PREP, NUM, DIV, WRITE, DONE} state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_n;
  logic signed [S1_W-1:0]  r_sx, r_sy, r_sz;
  logic signed [S2_W-1:0]  r_sxx, r_sxy, r_sxz, r_syy, r_syz, r_szz;
  logic [D_W-1:0]          r_d;
  logic [2:0]              r_k;
  logic [IT_W-1:0]         r_it;
  logic [NUM_W-1:0]        r_q;
  logic [D_W-1:0]          r_rem;
  logic                    r_neg;
  logic [4:0][OUT_W-1:0]   r_stg;

  logic signed [P_W-1:0]   w_x, w_y, w_z;
  logic signed [P_W-1:0]   w_pxx, w_pxy, w_pxz, w_pyy, w_pyz, w_pzz;
  logic [D_W-1:0]          w_n2;
  logic signed [S2_W-1:0]  w_sij;
  logic signed [S1_W-1:0]  w_si, w_sj;
  logic signed [NUM_W-1:0] w_ne, w_sije, w_sie, w_sje, w_num;
  logic [NUM_W-1:0]        w_mag;
  logic [D_W:0]            w_rsh;
  logic                    w_ge;
  logic [D_W-1:0]          w_rnext;
  logic [OUT_W-1:0]        w_qneg, w_sat;

  assign w_x   = P_W'(pt_x);
  assign w_y   = P_W'(pt_y);
  assign w_z   = P_W'(pt_z);
  assign w_pxx = w_x * w_x;
  assign w_pxy = w_x * w_y;
  assign w_pxz = w_x * w_z;
  assign w_pyy = w_y * w_y;
  assign w_pyz = w_y * w_z;
  assign w_pzz = w_z * w_z;
  assign w_n2  = D_W'(r_n);

  // entry order k: xx, xy, xz, yy, yz, zz
  always_comb begin
    w_sij = (r_k == 3'd0) ? r_sxx : (r_k == 3'd1) ? r_sxy : (r_k == 3'd2) ? r_sxz :
            (r_k == 3'd3) ? r_syy : (r_k == 3'd4) ? r_syz : r_szz;
    w_si  = (r_k < 3'd3) ? r_sx : (r_k < 3'd5) ? r_sy : r_sz;
    w_sj  = (r_k == 3'd0) ? r_sx : (r_k == 3'd1 || r_k == 3'd3) ? r_sy : r_sz;
  end

  assign w_ne    = NUM_W'($signed({1'b0, r_n}));
  assign w_sije  = NUM_W'(w_sij);
  assign w_sie   = NUM_W'(w_si);
  assign w_sje   = NUM_W'(w_sj);
  assign w_num   = w_ne * w_sije - w_sie * w_sje;
  assign w_mag   = w_num[NUM_W-1] ? -w_num : w_num;

  assign w_rsh   = {r_rem, r_q[NUM_W-1]};
  assign w_ge    = w_rsh >= {1'b0, r_d};
  assign w_rnext = D_W'(w_ge ? w_rsh - {1'b0, r_d} : w_rsh);

  assign w_qneg  = -r_q[OUT_W-1:0];
  assign w_sat   = r_neg ? ((r_q > LIM) ? SAT_MIN : w_qneg) : ((r_q >= LIM) ? SAT_MAX : r_q[OUT_W-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      pt_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      m1       <= '0;
      m2       <= '0;
      m3       <= '0;
      m5       <= '0;
      m6       <= '0;
      m9       <= '0;
      r_n      <= '0;
      r_sx     <= '0;
      r_sy     <= '0;
      r_sz     <= '0;
      r_sxx    <= '0;
      r_sxy    <= '0;
      r_sxz    <= '0;
      r_syy    <= '0;
      r_syz    <= '0;
      r_szz    <= '0;
      r_d      <= '0;
      r_k      <= '0;
      r_it     <= '0;
      r_q      <= '0;
      r_rem    <= '0;
      r_neg    <= 1'b0;
      r_stg    <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state  <= ACC;
          pt_ready <= 1'b1;
          busy     <= 1'b1;
          ovf      <= 1'b0;
          r_n      <= '0;
          r_sx     <= '0;
          r_sy     <= '0;
          r_sz     <= '0;
          r_sxx    <= '0;
          r_sxy    <= '0;
          r_sxz    <= '0;
          r_syy    <= '0;
          r_syz    <= '0;
          r_szz    <= '0;
        end
        ACC: if (pt_valid) begin
          // a full counter drops the point but pt_last still closes the frame
          if (&r_n) ovf <= 1'b1;
          else begin
            r_n   <= r_n + CNT_W'(1);
            r_sx  <= r_sx + S1_W'(pt_x);
            r_sy  <= r_sy + S1_W'(pt_y);
            r_sz  <= r_sz + S1_W'(pt_z);
            r_sxx <= r_sxx + S2_W'(w_pxx);
            r_sxy <= r_sxy + S2_W'(w_pxy);
            r_sxz <= r_sxz + S2_W'(w_pxz);
            r_syy <= r_syy + S2_W'(w_pyy);
            r_syz <= r_syz + S2_W'(w_pyz);
            r_szz <= r_szz + S2_W'(w_pzz);
          end
          if (pt_last) begin
            r_state  <= PREP;
            pt_ready <= 1'b0;
          end
        end
        PREP: begin
          r_d     <= w_n2 * w_n2;
          r_k     <= '0;
          r_state <= NUM;
        end
        NUM: begin
          r_q     <= w_mag;
          r_neg   <= w_num[NUM_W-1];
          r_rem   <= '0;
          r_it    <= '0;
          r_state <= DIV;
        end
        DIV: begin
          r_rem <= w_rnext;
          r_q   <= {r_q[NUM_W-2:0], w_ge};
          r_it  <= r_it + IT_W'(1);
          if (r_it == IT_W'(NUM_W-1)) r_state <= WRITE;
        end
        WRITE: if (r_k == 3'd5) begin
          // the last entry bypasses staging so all outputs update on the same edge
          m1      <= r_stg[0];
          m2      <= r_stg[1];
          m3      <= r_stg[2];
          m5      <= r_stg[3];
          m6      <= r_stg[4];
          m9      <= w_sat;
          done    <= 1'b1;
          r_state <= DONE;
        end else begin
          r_stg[r_k] <= w_sat;
          r_k        <= r_k + 3'd1;
          r_state    <= NUM;
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_covariance_calc.sv
// tb_covariance_calc: directed frames; the driver queues expected results, a monitor checks them on done.
module tb_covariance_calc;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, pt_valid = 1'b0, pt_last = 1'b0;
  logic signed [15:0] pt_x = '0, pt_y = '0, pt_z = '0;
  logic pt_ready, busy, done, ovf;
  logic signed [20:0] m1, m2, m3, m5, m6, m9;

  covariance_calc dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z), .pt_last(pt_last), .busy(busy), .done(done),
    .ovf(ovf), .m1(m1), .m2(m2), .m3(m3), .m5(m5), .m6(m6), .m9(m9)
  );

  always #5 clk = ~clk;

  typedef struct {
    int e1, e2, e3, e5, e6, e9;
    bit eovf;
    int acc;
  } exp_t;

  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0;
  int px [0:1023], py [0:1023], pz [0:1023];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (done) begin
      if (sb.size() == 0) chk("spurious_done", int'(done), 0);
      else begin
        e = sb.pop_front();
        chk("m1", int'(m1), e.e1);
        chk("m2", int'(m2), e.e2);
        chk("m3", int'(m3), e.e3);
        chk("m5", int'(m5), e.e5);
        chk("m6", int'(m6), e.e6);
        chk("m9", int'(m9), e.e9);
        chk("ovf", int'(ovf), int'(e.eovf));
        chk("latency", cyc - e.acc, 337);
      end
      @(negedge clk);
      chk("done_one_cycle", int'(done), 0);
      chk("idle_after_done", int'(busy), 0);
    end
  end

  task automatic run_frame(input int n, input int e1, e2, e3, e5, e6, e9,
                           input bit eovf, input bit overlap, input bit bstart);
    exp_t e;
    int t;
    @(posedge clk); #1;
    chk("ready_idle", int'(pt_ready), 0);
    start = 1'b1;
    if (overlap) begin
      pt_valid = 1'b1;
      pt_x = 16'(px[0]); pt_y = 16'(py[0]); pt_z = 16'(pz[0]);
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("ready_acc", int'(pt_ready), 1);
    chk("busy_acc", int'(busy), 1);
    chk("ovf_cleared", int'(ovf), 0);
    for (int i = 0; i < n; i++) begin
      pt_valid = 1'b1;
      pt_x = 16'(px[i]); pt_y = 16'(py[i]); pt_z = 16'(pz[i]);
      pt_last = (i == n - 1);
      @(posedge clk); #1;
    end
    pt_valid = 1'b0;
    pt_last = 1'b0;
    e = '{e1, e2, e3, e5, e6, e9, eovf, cyc};
    sb.push_back(e);
    if (bstart) begin
      repeat (50) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("busy_start_ignored", int'(busy), 1);
    end
    t = 0;
    while (sb.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic set_pt(input int i, input int x, y, z);
    px[i] = x; py[i] = y; pz[i] = z;
  endtask

  task automatic load_t1();
    set_pt(0, 10, 0, 0); set_pt(1, -10, 0, 0); set_pt(2, 0, 20, 0); set_pt(3, 0, -20, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(pt_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_m1", int'(m1), 0);
    chk("rst_m9", int'(m9), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    load_t1();
    run_frame(4, 50, 0, 0, 200, 0, 0, 1'b0, 1'b0, 1'b0);

    set_pt(0, 1, -1, 5); set_pt(1, 3, -3, 5);
    run_frame(2, 1, -1, 0, 1, 0, 0, 1'b0, 1'b1, 1'b0);

    set_pt(0, 1, -1, 0); set_pt(1, 2, -1, 0); set_pt(2, 3, -2, 0);
    run_frame(3, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

    set_pt(0, 32767, -32768, 0); set_pt(1, -32768, 32767, 0);
    run_frame(2, 1048575, -1048576, 0, 1048575, 0, 0, 1'b0, 1'b0, 1'b0);

    set_pt(0, 0, 0, 0); set_pt(1, 2, 4, 6);
    run_frame(2, 1, 2, 3, 4, 6, 9, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 1023; i++) set_pt(i, (i % 2 == 0) ? 10 : -10, 0, 0);
    set_pt(1023, 1000, 1000, 1000);
    run_frame(1024, 99, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);

    load_t1();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("t6_ovf_cleared", int'(ovf), 0);
    for (int i = 0; i < 4; i++) begin
      pt_valid = 1'b1;
      pt_x = 16'(px[i]); pt_y = 16'(py[i]); pt_z = 16'(pz[i]);
      pt_last = (i == 3);
      @(posedge clk); #1;
    end
    pt_valid = 1'b0;
    pt_last = 1'b0;
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk("t6_m1", int'(m1), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_ready", int'(pt_ready), 0);
    chk("t6_done", int'(done), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (400) @(posedge clk);
    run_frame(4, 50, 0, 0, 200, 0, 0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule
